jt49_bus_drv: RTL and testbench
===============================

JT49_BUS_DRV -- requirements
Module: jt49_bus_drv

Interface
REQ-001 SHALL have parameter PHASE_CYC, default 2: number of cen cycles each active bus phase (address, write, read) is held.
REQ-002 SHALL have parameter GAP_CYC, default 1: number of cen cycles of inactive bus ({bdir,bc1}=00) after each active phase.
REQ-003 SHALL have port clk  in  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-005 SHALL have port cen  in  1  clock enable; state and counters advance only when high.
REQ-006 SHALL have port req  in  1  transfer request; sampled in IDLE on a cen cycle.
REQ-007 SHALL have port wr  in  1  1 = register write, 0 = register read.
REQ-008 SHALL have port addr  in  4  PSG register number.
REQ-009 SHALL have port wdata  in  8  write data.
REQ-010 SHALL have port busy  out  1  high from accept until the cycle ack is asserted.
REQ-011 SHALL have port ack  out  1  one-clk pulse at transfer completion.
REQ-012 SHALL have port rdata  out  8  read result; valid when ack pulses for a read.
REQ-013 SHALL have port bdir  out  1  PSG BDIR pin.
REQ-014 SHALL have port bc1  out  1  PSG BC1 pin.
REQ-015 SHALL have port bus_dout  out  8  data driven to PSG din.
REQ-016 SHALL have port bus_din  in  8  data returned from PSG dout.

Function
REQ-017 SHALL implement states IDLE, ADDR, GAP_A, WRITE, READ, GAP_D.
REQ-018 In IDLE with cen and req high, SHALL capture wr/addr/wdata, assert busy and enter ADDR.
REQ-019 ADDR SHALL drive {bdir,bc1}=11 and bus_dout={4'h0,addr} for PHASE_CYC cen cycles, then enter GAP_A.
REQ-020 GAP_A SHALL drive {bdir,bc1}=00 for GAP_CYC cen cycles, then enter WRITE if wr else READ.
REQ-021 WRITE SHALL drive {bdir,bc1}=10 and bus_dout=wdata for PHASE_CYC cen cycles, then enter GAP_D.
REQ-022 READ SHALL drive {bdir,bc1}=01 for PHASE_CYC cen cycles and capture bus_din into rdata on its final cen cycle.
REQ-023 GAP_D SHALL drive 00 for GAP_CYC cen cycles; on its final cen cycle SHALL pulse ack for one clk, deassert busy, return to IDLE.
REQ-024 req while busy SHALL be ignored; a req held high at ack SHALL start a new transfer no earlier than the next cen cycle in IDLE.
REQ-025 Transfer latency from accept to ack SHALL be exactly 2*(PHASE_CYC+GAP_CYC) cen cycles (address phase included).
REQ-026 bus_dout SHALL be 8'h00 in IDLE, GAP and READ states.
REQ-027 cen low SHALL freeze state, counters and outputs; ack SHALL never be asserted on a cen-low cycle.
REQ-028 PHASE_CYC and GAP_CYC SHALL be ≥1; phase counter width SHALL be $clog2 of max(PHASE_CYC,GAP_CYC)+1.

Reset
REQ-029 rst SHALL force, on the next clk edge and regardless of state: IDLE, {bdir,bc1}=00, bus_dout=0, busy=0, ack=0, rdata=0, counters=0.
REQ-030 A transfer interrupted by rst SHALL be abandoned without ack.

Configuration
REQ-031 Macro JT49_BUS_DRV_ADDRSKIP_EN, when defined, SHALL keep a last-latched-address register plus valid flag and go from IDLE directly to WRITE/READ when addr equals it and the flag is set.
REQ-032 With skip, latency SHALL be PHASE_CYC+GAP_CYC cen cycles; valid flag SHALL be cleared by rst and set on completion of every ADDR phase.
REQ-033 Without the macro, every transfer SHALL include the ADDR phase and no address-tracking registers SHALL exist.

Structure
REQ-034 State encoding and bus-phase constants (ADDR=2'b11, WR=2'b10, RD=2'b01, INACT=2'b00) SHALL live in shared package jt49_bus_pkg.
REQ-035 The block SHALL be a single module; no sub-module.

Verification
REQ-036 Write addr=7, wdata=8'h38, defaults -> bus 11/07 ×2, 00 ×1, 10/38 ×2, 00 ×1; ack at cen 6; jt49_bus register 7 reads 8'h38.
REQ-037 Read addr=0 with bus_din=8'h5A during READ -> {bdir,bc1}=01 for 2 cen cycles; rdata=8'h5A at ack.
REQ-038 cen toggling 1-in-3 during a write -> identical phase sequence, latency 18 clk, single ack.
REQ-039 rst asserted in WRITE -> next edge bdir=bc1=0, busy=0, no ack; following req completes normally.
REQ-040 With JT49_BUS_DRV_ADDRSKIP_EN, two writes to addr=8 -> second skips ADDR, ack after 3 cen cycles; after rst first write includes ADDR.
REQ-041 req held high continuously -> back-to-back transfers, each acked once, no phase overlap.

Source files
------------

// File: rtl/jt49_bus_pkg.sv
// Shared definitions for the jt49 PSG bus driver: FSM state encoding and
// the {bdir,bc1} bus-phase codes of the AY-3-8910/YM2149 interface.
package jt49_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_GAP_A = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4,
        ST_GAP_D = 3'd5
    } state_t;

    localparam logic [1:0] BUS_ADDR  = 2'b11;
    localparam logic [1:0] BUS_WR    = 2'b10;
    localparam logic [1:0] BUS_RD    = 2'b01;
    localparam logic [1:0] BUS_INACT = 2'b00;

endpackage

// File: rtl/jt49_bus_drv.sv
// Sequences one PSG register access over BDIR/BC1: address latch, gap, data phase, gap.
// Optional macro JT49_BUS_DRV_ADDRSKIP_EN skips the address phase when the PSG already holds addr.
module jt49_bus_drv
    import jt49_bus_pkg::*;
#(
    parameter int PHASE_CYC = 2,
    parameter int GAP_CYC   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       req,
    input  logic       wr,
    input  logic [3:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       ack,
    output logic [7:0] rdata,
    output logic       bdir,
    output logic       bc1,
    output logic [7:0] bus_dout,
    input  logic [7:0] bus_din
);

    localparam int CNT_MAX = (PHASE_CYC > GAP_CYC) ? PHASE_CYC : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] PH_LAST  = CNT_W'(PHASE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_q, wr_d;
    logic [3:0]       addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             phase_done;
    logic             skip_hit;
    logic [1:0]       bus_ph;

`ifdef JT49_BUS_DRV_ADDRSKIP_EN
    logic [3:0] last_addr_q, last_addr_d;
    logic       addr_vld_q, addr_vld_d;
    assign skip_hit = addr_vld_q && (addr == last_addr_q);
`else
    assign skip_hit = 1'b0;
`endif

    // Phase length depends on whether the current state drives the bus or idles it
    always_comb begin
        phase_done = 1'b0;
        case (state_q)
            ST_ADDR, ST_WRITE, ST_READ: phase_done = (cnt_q == PH_LAST);
            ST_GAP_A, ST_GAP_D:         phase_done = (cnt_q == GAP_LAST);
            default:                    phase_done = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef JT49_BUS_DRV_ADDRSKIP_EN
            last_addr_q <= '0;
            addr_vld_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef JT49_BUS_DRV_ADDRSKIP_EN
            last_addr_q <= last_addr_d;
            addr_vld_q  <= addr_vld_d;
`endif
        end
    end

    // Everything below only moves on cen, so a low cen freezes the whole block
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef JT49_BUS_DRV_ADDRSKIP_EN
        last_addr_d = last_addr_q;
        addr_vld_d  = addr_vld_q;
`endif
        if (cen) begin
            if (state_q == ST_IDLE) begin
                if (req) begin
                    wr_d    = wr;
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = '0;
                    if (skip_hit) state_d = wr ? ST_WRITE : ST_READ;
                    else          state_d = ST_ADDR;
                end
            end else if (phase_done) begin
                cnt_d = '0;
                case (state_q)
                    ST_ADDR: begin
                        state_d = ST_GAP_A;
`ifdef JT49_BUS_DRV_ADDRSKIP_EN
                        last_addr_d = addr_q;
                        addr_vld_d  = 1'b1;
`endif
                    end
                    ST_GAP_A: state_d = wr_q ? ST_WRITE : ST_READ;
                    ST_WRITE: state_d = ST_GAP_D;
                    ST_READ: begin
                        state_d = ST_GAP_D;
                        rdata_d = bus_din;
                    end
                    ST_GAP_D: state_d = ST_IDLE;
                    default:  state_d = ST_IDLE;
                endcase
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        bus_ph   = BUS_INACT;
        bus_dout = 8'h00;
        case (state_q)
            ST_ADDR: begin
                bus_ph   = BUS_ADDR;
                bus_dout = {4'h0, addr_q};
            end
            ST_WRITE: begin
                bus_ph   = BUS_WR;
                bus_dout = wdata_q;
            end
            ST_READ: bus_ph = BUS_RD;
            default: bus_ph = BUS_INACT;
        endcase
        bdir  = bus_ph[1];
        bc1   = bus_ph[0];
        busy  = (state_q != ST_IDLE);
        // Gated by rst so a transfer reset on its last cycle is never acknowledged
        ack   = cen && !rst && (state_q == ST_GAP_D) && (cnt_q == GAP_LAST);
        rdata = rdata_q;
    end

endmodule

// File: tb/tb_jt49_bus_drv.sv
// Randomized bench for jt49_bus_drv: each accepted transfer is expanded into the
// list of bus phases it must produce, one entry per cen cycle, and consumed as cen ticks.
module tb_jt49_bus_drv;

    localparam int P = 2;
    localparam int G = 1;

    logic       clk = 1'b0;
    logic       rst, cen, req, wr;
    logic [3:0] addr;
    logic [7:0] wdata, bus_din;
    logic       busy, ack, bdir, bc1;
    logic [7:0] rdata, bus_dout;

    jt49_bus_drv #(.PHASE_CYC(P), .GAP_CYC(G)) dut (
        .clk(clk), .rst(rst), .cen(cen), .req(req), .wr(wr), .addr(addr),
        .wdata(wdata), .busy(busy), .ack(ack), .rdata(rdata), .bdir(bdir),
        .bc1(bc1), .bus_dout(bus_dout), .bus_din(bus_din)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] ph;
        logic [7:0] dout;
        logic       cap;
        logic       adr_done;
    } ent_t;

    ent_t       m_seq[$];
    bit         m_busy = 0;
    logic [7:0] m_rdata = 8'h00;
    bit         m_vld = 0;
    logic [3:0] m_last = 4'h0;
    logic [3:0] m_addr = 4'h0;
    int         m_acks = 0;

    int checks = 0, failures = 0;
    int clk_n = 0, cen_n = 0;
    int n_acc = 0, n_ack = 0;
    int acc_clk = 0, acc_cen = 0, ack_clk = 0, ack_cen = 0;
    logic [7:0] psg_reg[16];
    logic [3:0] psg_a = 4'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expand one request into its per-cen-cycle bus phases
    task automatic build(input bit w, input logic [3:0] a, input logic [7:0] wd);
        bit skip;
        skip = 0;
`ifdef JT49_BUS_DRV_ADDRSKIP_EN
        skip = m_vld && (a == m_last);
`endif
        if (!skip) begin
            for (int i = 0; i < P; i++) m_seq.push_back('{2'b11, {4'h0, a}, 1'b0, i == P - 1});
            for (int i = 0; i < G; i++) m_seq.push_back('{2'b00, 8'h00, 1'b0, 1'b0});
        end
        for (int i = 0; i < P; i++)
            m_seq.push_back('{w ? 2'b10 : 2'b01, w ? wd : 8'h00, !w && (i == P - 1), 1'b0});
        for (int i = 0; i < G; i++) m_seq.push_back('{2'b00, 8'h00, 1'b0, 1'b0});
    endtask

    // One clock: drive, check outputs mid-cycle, advance model at the edge
    task automatic cyc(input bit c, input bit r, input bit w, input logic [3:0] a,
                       input logic [7:0] wd, input logic [7:0] di, input bit rs);
        logic [9:0] exp_bus;
        bit         exp_ack;
        ent_t       e;
        cen = c; req = r; wr = w; addr = a; wdata = wd; bus_din = di; rst = rs;
        #1;
        exp_bus = m_busy ? {m_seq[0].ph, m_seq[0].dout} : 10'h000;
        exp_ack = c && !rs && m_busy && (m_seq.size() == 1);
        chk("bus", {bdir, bc1, bus_dout}, exp_bus);
        chk("busy", busy, m_busy);
        chk("ack", ack, exp_ack);
        chk("rdata", rdata, m_rdata);
        if (exp_ack) m_acks++;
        if (ack) begin n_ack++; ack_clk = clk_n; ack_cen = cen_n; end
        if (c && !rs) begin
            if ({bdir, bc1} == 2'b11) psg_a = bus_dout[3:0];
            else if ({bdir, bc1} == 2'b10) psg_reg[psg_a] = bus_dout;
        end
        if (c && r && !rs && !m_busy) begin n_acc++; acc_clk = clk_n; acc_cen = cen_n; end
        @(posedge clk);
        if (rs) begin
            m_seq.delete(); m_busy = 0; m_rdata = 8'h00; m_vld = 0;
        end else if (c) begin
            if (m_busy) begin
                e = m_seq.pop_front();
                if (e.cap) m_rdata = di;
                if (e.adr_done) begin m_vld = 1; m_last = m_addr; end
                if (m_seq.size() == 0) m_busy = 0;
            end else if (r) begin
                build(w, a, wd); m_busy = 1; m_addr = a;
            end
        end
        clk_n++;
        if (c) cen_n++;
        #1;
    endtask

    task automatic xfer(input bit w, input logic [3:0] a, input logic [7:0] wd,
                        input logic [7:0] di, input int period,
                        output int lat_cen, output int lat_clk);
        int acc0, ack0;
        acc0 = n_acc; ack0 = n_ack;
        for (int k = 0; k < 400; k++) begin
            cyc((k % period) == 0, n_acc == acc0, w, a, wd, di, 1'b0);
            if (n_ack != ack0) break;
        end
        chk("xfer_ack_count", n_ack - ack0, 1);
        lat_cen = ack_cen - acc_cen;
        lat_clk = ack_clk - acc_clk;
    endtask

    int lc, lk, a0, m0;

    initial begin
        for (int i = 0; i < 16; i++) psg_reg[i] = 8'h00;
        rst = 1; cen = 0; req = 0; wr = 0; addr = 0; wdata = 0; bus_din = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_bus", {bdir, bc1, bus_dout}, 0);
        chk("reset_rdata", rdata, 0);
        cyc(1, 0, 0, 0, 0, 0, 1);

        // Write 7 <- 0x38 at full cen rate
        xfer(1, 4'd7, 8'h38, 8'h00, 1, lc, lk);
        chk("wr_latency_cen", lc, 2 * (P + G));
        chk("psg_reg7", psg_reg[7], 8'h38);

        // Read 0, PSG returns 0x5A
        xfer(0, 4'd0, 8'h00, 8'h5A, 1, lc, lk);
        chk("rd_latency_cen", lc, 2 * (P + G));
        chk("rd_data", rdata, 8'h5A);

        // cen 1-in-3 stretches the same sequence threefold in clocks
        xfer(1, 4'd9, 8'hA5, 8'h00, 3, lc, lk);
        chk("cen3_latency_clk", lk, 3 * 2 * (P + G));
        chk("psg_reg9", psg_reg[9], 8'hA5);

        // Reset while in the write phase abandons the transfer
        a0 = n_ack;
        for (int k = 0; k < 50; k++) begin
            if (m_busy && m_seq[0].ph == 2'b10) break;
            cyc(1, !m_busy, 1, 4'd3, 8'h77, 8'h00, 0);
        end
        chk("reached_write", {bdir, bc1}, 2'b10);
        cyc(1, 0, 1, 4'd3, 8'h77, 8'h00, 1);
        chk("rst_bus", {bdir, bc1}, 2'b00);
        chk("rst_busy", busy, 0);
        chk("rst_no_ack", n_ack - a0, 0);
        xfer(1, 4'd3, 8'h77, 8'h00, 1, lc, lk);
        chk("post_rst_latency", lc, 2 * (P + G));

`ifdef JT49_BUS_DRV_ADDRSKIP_EN
        xfer(1, 4'd8, 8'h11, 8'h00, 1, lc, lk);
        chk("skip_first", lc, 2 * (P + G));
        xfer(1, 4'd8, 8'h22, 8'h00, 1, lc, lk);
        chk("skip_second", lc, P + G);
        cyc(1, 0, 0, 0, 0, 0, 1);
        xfer(1, 4'd8, 8'h33, 8'h00, 1, lc, lk);
        chk("skip_after_rst", lc, 2 * (P + G));
`endif

        // req held high: back-to-back transfers
        a0 = n_ack; m0 = m_acks;
        for (int k = 0; k < 200; k++)
            cyc($urandom_range(0, 3) != 0, 1, $urandom_range(0, 1), 4'($urandom_range(0, 3)),
                8'($urandom), 8'($urandom), 0);
        chk("b2b_acks", n_ack - a0, m_acks - m0);
        chk("b2b_some_acks", (n_ack - a0) > 5, 1);

        // Fully random traffic with occasional reset
        for (int k = 0; k < 3000; k++)
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1),
                4'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                $urandom_range(0, 199) == 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
